wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter sitting between the execute/load stages and the register file. It merges the single-cycle ALU result stream and the variable-latency load return stream into the one registered write port (w_reg_req/addr/data) that drives both the register file and the forwarding unit. It also carries the CSR write port through the same stage. Load returns are buffered in a small FIFO, and a younger ALU write to the same destination kills any stale buffered load.

## Interface
- REG_ADDR_W, 5, GPR address width
- REG_DATA_W, 32, GPR/CSR data width
- CSR_ADDR_W, 12, CSR address width
- LOAD_FIFO_DEPTH, 2, load return buffer entries; power of two, ≥2

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_req_i  in  1  ALU result valid this cycle (no back-pressure)
- alu_addr_i  in  REG_ADDR_W  ALU destination register
- alu_data_i  in  REG_DATA_W  ALU result
- ld_valid_i  in  1  load return valid
- ld_ready_o  out  1  load return accepted when ld_valid_i & ld_ready_o
- ld_addr_i  in  REG_ADDR_W  load destination register
- ld_data_i  in  REG_DATA_W  load data
- csr_req_i  in  1  CSR write request
- csr_addr_i  in  CSR_ADDR_W  CSR address
- csr_data_i  in  REG_DATA_W  CSR write data
- w_reg_req_o  out  1  GPR write enable
- w_reg_addr_o  out  REG_ADDR_W  GPR write address
- w_reg_data_o  out  REG_DATA_W  GPR write data
- w_csr_req_o  out  1  CSR write enable
- w_csr_addr_o  out  CSR_ADDR_W  CSR write address
- w_csr_data_o  out  REG_DATA_W  CSR write data
- ld_pending_o  out  1  FIFO holds ≥1 live entry
- ld_count_o  out  $clog2(LOAD_FIFO_DEPTH)+1  live entry count

## Operation
- Load FIFO: circular buffer with read/write pointers and a per-entry live bit. ld_ready_o = (count != LOAD_FIFO_DEPTH). It depends only on registered count, so there is no same-cycle pop bypass.
- Accepted loads with ld_addr_i == 0 are not pushed. They are consumed: ready is honoured and no entry is taken.
- Each cycle the output arbitration is as follows:
  - If alu_req_i and alu_addr_i != 0: grant the ALU. The head entry stays in the FIFO.
  - Else if the head is live: grant the head and pop it.
  - Else if the head is a killed entry: pop it silently with no write.
  - Else: no write.
- ALU writes to x0 are dropped and do not block the FIFO head that cycle.
- Kill rule: when alu_req_i and alu_addr_i != 0, every FIFO entry with a matching address has its live bit cleared that cycle. This includes the head when it is not granted.
- A load pushed in the same cycle as a matching ALU write is not killed, because the load is younger.
- Count decrements on any pop, live or killed. ld_pending_o = OR of live bits. ld_count_o counts live plus unpopped killed entries, i.e. FIFO occupancy.
- CSR path: a registered pass-through with no arbitration. w_csr_req_o = csr_req_i delayed one cycle, with address and data captured with it.
- Data/address outputs hold their last value when the req output is low.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - w_reg_req_o=0, w_reg_addr_o=0, w_reg_data_o=0
  - w_csr_req_o=0, w_csr_addr_o=0, w_csr_data_o=0
  - pointers=0, count=0, all live bits=0
  - ld_ready_o=1, ld_pending_o=0
- Reset mid-operation discards all buffered loads.
- ALU path latency is 1 cycle: alu_req_i at edge N gives w_reg_req_o high after edge N+1.
- Load path latency is 2 cycles minimum: accept at edge N, write visible after edge N+1 if not pre-empted. A push into an empty FIFO cannot pop in the same cycle.
- Simultaneous push and pop while full is impossible, since ready is low when full. Push and pop on a non-full, non-empty FIFO keeps count unchanged.
- Pointer wrap is modulo LOAD_FIFO_DEPTH.
- CSR latency is 1 cycle, independent of GPR traffic.

## Test plan
- Reset: hold rst_n=0 mid-stream with 2 loads buffered -> all outputs 0, ld_ready_o=1, ld_count_o=0. After release, no stale write appears.
- ALU priority: ld push x5=0xAAAA at cycle 0, then alu_req x7=0x1234 on cycles 1–3 -> w_reg shows x7 three times. x5=0xAAAA is written on cycle 5 (output after the edge ending cycle 4).
- Kill: push ld x3=0x11, then alu x3=0x22 while the load is still buffered -> only x3=0x22 is written. The killed entry pops with no write and the count returns to 0.
- Same-cycle push+ALU same address: ld x4=0x55 and alu x4=0x66 in one cycle -> x4=0x66, then x4=0x55 the next cycle, with no kill.
- Full/back-pressure: hold alu_req continuously and push 3 loads -> ld_ready_o drops after 2. After alu_req deasserts, loads drain in order. Cover pointer wrap over 5 push/pop rounds.
- x0 and CSR: alu x0 and ld x0 -> no w_reg_req. csr_req 0x300=0xDEAD concurrent with an ALU write -> both appear on the same following cycle.

Source files
------------

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Write-back arbiter between the execute/load stages and the register file.
// Merges the single-cycle ALU result stream and the variable-latency load
// return stream into one registered GPR write port. Load returns wait in a
// small circular FIFO. A younger ALU write to the same destination kills any
// stale buffered load. The CSR write port is a one-cycle registered
// pass-through.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   alu_req_i/addr_i/data_i       ALU result, no back-pressure
//   ld_valid_i/ready_o/addr_i/data_i   load return handshake
//   csr_req_i/addr_i/data_i       CSR write request
//   w_reg_req_o/addr_o/data_o     registered GPR write port
//   w_csr_req_o/addr_o/data_o     registered CSR write port
//   ld_pending_o                  at least one live load buffered
//   ld_count_o                    FIFO occupancy (live plus unpopped killed)
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int REG_ADDR_W      = 5,
    parameter int REG_DATA_W      = 32,
    parameter int CSR_ADDR_W      = 12,
    parameter int LOAD_FIFO_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,

    input  logic                               alu_req_i,
    input  logic [REG_ADDR_W-1:0]              alu_addr_i,
    input  logic [REG_DATA_W-1:0]              alu_data_i,

    input  logic                               ld_valid_i,
    output logic                               ld_ready_o,
    input  logic [REG_ADDR_W-1:0]              ld_addr_i,
    input  logic [REG_DATA_W-1:0]              ld_data_i,

    input  logic                               csr_req_i,
    input  logic [CSR_ADDR_W-1:0]              csr_addr_i,
    input  logic [REG_DATA_W-1:0]              csr_data_i,

    output logic                               w_reg_req_o,
    output logic [REG_ADDR_W-1:0]              w_reg_addr_o,
    output logic [REG_DATA_W-1:0]              w_reg_data_o,

    output logic                               w_csr_req_o,
    output logic [CSR_ADDR_W-1:0]              w_csr_addr_o,
    output logic [REG_DATA_W-1:0]              w_csr_data_o,

    output logic                               ld_pending_o,
    output logic [$clog2(LOAD_FIFO_DEPTH):0]   ld_count_o
);

    localparam int PTR_W = $clog2(LOAD_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LOAD_FIFO_DEPTH);

    // FIFO control state
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [CNT_W-1:0]           r_count;
    logic [LOAD_FIFO_DEPTH-1:0] r_live;

    // FIFO storage (not reset; validity is tracked by count and live bits)
    logic [REG_ADDR_W-1:0]      r_addr [LOAD_FIFO_DEPTH];
    logic [REG_DATA_W-1:0]      r_data [LOAD_FIFO_DEPTH];

    // Registered output ports
    logic                       r_reg_req;
    logic [REG_ADDR_W-1:0]      r_reg_addr;
    logic [REG_DATA_W-1:0]      r_reg_data;
    logic                       r_csr_req;
    logic [CSR_ADDR_W-1:0]      r_csr_addr;
    logic [REG_DATA_W-1:0]      r_csr_data;

    logic                       w_alu_grant;
    logic                       w_head_busy;
    logic                       w_head_live;
    logic                       w_pop;
    logic                       w_push;
    logic [LOAD_FIFO_DEPTH-1:0] w_live_nxt;

    // ALU writes to x0 are dropped and never pre-empt the FIFO head.
    assign w_alu_grant = alu_req_i && (alu_addr_i != '0);
    assign w_head_busy = (r_count != '0);
    assign w_head_live = w_head_busy && r_live[r_rd_ptr];
    // The head leaves whenever the ALU does not own the port, whether it is
    // written (live) or silently discarded (killed).
    assign w_pop       = w_head_busy && !w_alu_grant;

    // Ready comes from the registered count only: no same-cycle pop bypass.
    assign ld_ready_o  = (r_count != FULL_CNT);
    // Loads to x0 complete the handshake but take no entry.
    assign w_push      = ld_valid_i && ld_ready_o && (ld_addr_i != '0);

    always_comb begin
        w_live_nxt = r_live;
        // Kill older entries overwritten by this ALU write. The load being
        // pushed this cycle is younger and is set live below.
        if (w_alu_grant) begin
            for (int i = 0; i < LOAD_FIFO_DEPTH; i++) begin
                if (r_addr[i] == alu_addr_i) begin
                    w_live_nxt[i] = 1'b0;
                end
            end
        end
        if (w_pop) begin
            w_live_nxt[r_rd_ptr] = 1'b0;
        end
        if (w_push) begin
            w_live_nxt[r_wr_ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_live   <= '0;
        end else begin
            r_live <= w_live_nxt;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= ld_addr_i;
            r_data[r_wr_ptr] <= ld_data_i;
        end
    end

    // GPR write port: ALU first, then a live head; address/data hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_req  <= 1'b0;
            r_reg_addr <= '0;
            r_reg_data <= '0;
        end else begin
            r_reg_req <= w_alu_grant || w_head_live;
            if (w_alu_grant) begin
                r_reg_addr <= alu_addr_i;
                r_reg_data <= alu_data_i;
            end else if (w_head_live) begin
                r_reg_addr <= r_addr[r_rd_ptr];
                r_reg_data <= r_data[r_rd_ptr];
            end
        end
    end

    // CSR write port: one-cycle pass-through, independent of GPR traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csr_req  <= 1'b0;
            r_csr_addr <= '0;
            r_csr_data <= '0;
        end else begin
            r_csr_req <= csr_req_i;
            if (csr_req_i) begin
                r_csr_addr <= csr_addr_i;
                r_csr_data <= csr_data_i;
            end
        end
    end

    assign w_reg_req_o  = r_reg_req;
    assign w_reg_addr_o = r_reg_addr;
    assign w_reg_data_o = r_reg_data;
    assign w_csr_req_o  = r_csr_req;
    assign w_csr_addr_o = r_csr_addr;
    assign w_csr_data_o = r_csr_data;
    assign ld_pending_o = |r_live;
    assign ld_count_o   = r_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Self-checking bench for wb_arbiter. A queue-based model of the write-back
// stage predicts every registered output each cycle; directed scenarios add
// hand-computed expectations, followed by a randomized traffic run.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = 12;
    localparam int DEPTH = 2;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic            clk;
    logic            rst_n;
    logic            alu_req;
    logic [AW-1:0]   alu_addr;
    logic [DW-1:0]   alu_data;
    logic            ld_valid;
    logic            ld_ready_o;
    logic [AW-1:0]   ld_addr;
    logic [DW-1:0]   ld_data;
    logic            csr_req;
    logic [CW-1:0]   csr_addr;
    logic [DW-1:0]   csr_data;
    logic            w_reg_req_o;
    logic [AW-1:0]   w_reg_addr_o;
    logic [DW-1:0]   w_reg_data_o;
    logic            w_csr_req_o;
    logic [CW-1:0]   w_csr_addr_o;
    logic [DW-1:0]   w_csr_data_o;
    logic            ld_pending_o;
    logic [CNTW-1:0] ld_count_o;

    wb_arbiter #(
        .REG_ADDR_W      (AW),
        .REG_DATA_W      (DW),
        .CSR_ADDR_W      (CW),
        .LOAD_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_req_i    (alu_req),
        .alu_addr_i   (alu_addr),
        .alu_data_i   (alu_data),
        .ld_valid_i   (ld_valid),
        .ld_ready_o   (ld_ready_o),
        .ld_addr_i    (ld_addr),
        .ld_data_i    (ld_data),
        .csr_req_i    (csr_req),
        .csr_addr_i   (csr_addr),
        .csr_data_i   (csr_data),
        .w_reg_req_o  (w_reg_req_o),
        .w_reg_addr_o (w_reg_addr_o),
        .w_reg_data_o (w_reg_data_o),
        .w_csr_req_o  (w_csr_req_o),
        .w_csr_addr_o (w_csr_addr_o),
        .w_csr_data_o (w_csr_data_o),
        .ld_pending_o (ld_pending_o),
        .ld_count_o   (ld_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            live;
    } ent_t;

    ent_t          q[$];
    logic          exp_req;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_csr_req;
    logic [CW-1:0] exp_csr_addr;
    logic [DW-1:0] exp_csr_data;
    bit            last_acc;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_req      = 1'b0;
        exp_addr     = '0;
        exp_data     = '0;
        exp_csr_req  = 1'b0;
        exp_csr_addr = '0;
        exp_csr_data = '0;
    endtask

    task automatic set_in(input bit ar, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                          input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                          input bit cr, input logic [CW-1:0] ca, input logic [DW-1:0] cd);
        alu_req  = ar;  alu_addr = aa;  alu_data = ad;
        ld_valid = lv;  ld_addr  = la;  ld_data  = ldd;
        csr_req  = cr;  csr_addr = ca;  csr_data = cd;
    endtask

    task automatic idle();
        set_in(0, '0, '0, 0, '0, '0, 0, '0, '0);
    endtask

    // One clock: predict from the current inputs, advance, compare outputs.
    task automatic step();
        bit   rdy;
        bit   alu;
        bit   pend;
        ent_t e;
        rdy = (q.size() < DEPTH);
        chk("ld_ready", ld_ready_o, rdy);
        last_acc = ld_valid && rdy;
        alu = alu_req && (alu_addr != '0);
        exp_req = 1'b0;
        if (alu) begin
            exp_req  = 1'b1;
            exp_addr = alu_addr;
            exp_data = alu_data;
            foreach (q[i]) if (q[i].a == alu_addr) q[i].live = 0;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            if (e.live) begin
                exp_req  = 1'b1;
                exp_addr = e.a;
                exp_data = e.d;
            end
        end
        if (last_acc && ld_addr != '0) q.push_back('{ld_addr, ld_data, 1'b1});
        exp_csr_req = csr_req;
        if (csr_req) begin
            exp_csr_addr = csr_addr;
            exp_csr_data = csr_data;
        end
        @(posedge clk);
        #1;
        pend = 0;
        foreach (q[i]) pend |= q[i].live;
        chk("reg_req",  w_reg_req_o,  exp_req);
        chk("reg_addr", w_reg_addr_o, exp_addr);
        chk("reg_data", w_reg_data_o, exp_data);
        chk("csr_req",  w_csr_req_o,  exp_csr_req);
        chk("csr_addr", w_csr_addr_o, exp_csr_addr);
        chk("csr_data", w_csr_data_o, exp_csr_data);
        chk("pending",  ld_pending_o, pend);
        chk("count",    ld_count_o,   q.size());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] got[$];
        int            n;
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reg_req",  w_reg_req_o,  0);
        chk("rst_reg_data", w_reg_data_o, 0);
        chk("rst_csr_req",  w_csr_req_o,  0);
        chk("rst_count",    ld_count_o,   0);
        chk("rst_ready",    ld_ready_o,   1);
        chk("rst_pending",  ld_pending_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU priority over a buffered load
        set_in(0, '0, '0, 1, 5'd5, 32'hAAAA, 0, '0, '0);
        step();
        set_in(1, 5'd7, 32'h1234, 0, '0, '0, 0, '0, '0);
        step();
        chk("prio_alu_req",  w_reg_req_o,  1);
        chk("prio_alu_addr", w_reg_addr_o, 7);
        chk("prio_alu_data", w_reg_data_o, 32'h1234);
        step();
        step();
        idle();
        step();
        chk("prio_ld_req",  w_reg_req_o,  1);
        chk("prio_ld_addr", w_reg_addr_o, 5);
        chk("prio_ld_data", w_reg_data_o, 32'hAAAA);

        // Kill a stale buffered load
        set_in(0, '0, '0, 1, 5'd3, 32'h11, 0, '0, '0);
        step();
        set_in(1, 5'd3, 32'h22, 0, '0, '0, 0, '0, '0);
        step();
        chk("kill_data",    w_reg_data_o, 32'h22);
        chk("kill_count",   ld_count_o,   1);
        chk("kill_pending", ld_pending_o, 0);
        idle();
        step();
        chk("kill_pop_req",   w_reg_req_o, 0);
        chk("kill_pop_count", ld_count_o,  0);

        // Same-cycle push and ALU write to the same register: no kill
        set_in(1, 5'd4, 32'h66, 1, 5'd4, 32'h55, 0, '0, '0);
        step();
        chk("same_alu_data", w_reg_data_o, 32'h66);
        idle();
        step();
        chk("same_ld_req",  w_reg_req_o,  1);
        chk("same_ld_data", w_reg_data_o, 32'h55);

        // Back-pressure while ALU holds the port, then in-order drain
        n = 0;
        for (int k = 0; k < 4; k++) begin
            set_in(1, 5'd9, 32'(k), 1, 5'(10 + n), 32'(100 + n), 0, '0, '0);
            step();
            if (last_acc) n++;
        end
        chk("full_ready", ld_ready_o, 0);
        chk("full_count", ld_count_o, 2);
        got.delete();
        for (int k = 0; k < 20 && (n < 3 || ld_count_o != 0); k++) begin
            if (n < 3) set_in(0, '0, '0, 1, 5'(10 + n), 32'(100 + n), 0, '0, '0);
            else idle();
            step();
            if (last_acc && ld_valid) n++;
            if (w_reg_req_o) got.push_back(w_reg_addr_o);
        end
        idle();
        chk("drain_n", got.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) chk("drain_order", got[k], 10 + k);
        end

        // Pointer wrap over several push/pop rounds
        for (int r = 0; r < 5; r++) begin
            set_in(0, '0, '0, 1, 5'(r + 1), 32'(r + 32'h500), 0, '0, '0);
            step();
            idle();
            step();
            chk("wrap_data", w_reg_data_o, r + 32'h500);
        end

        // x0 writes dropped
        set_in(1, 5'd0, 32'hFFFF, 1, 5'd0, 32'hEEEE, 0, '0, '0);
        step();
        chk("x0_req",   w_reg_req_o, 0);
        chk("x0_count", ld_count_o,  0);

        // CSR alongside an ALU write
        set_in(1, 5'd1, 32'hBEEF, 0, '0, '0, 1, 12'h300, 32'hDEAD);
        step();
        chk("csr_lit_req",  w_csr_req_o,  1);
        chk("csr_lit_addr", w_csr_addr_o, 12'h300);
        chk("csr_lit_data", w_csr_data_o, 32'hDEAD);
        chk("csr_lit_reg",  w_reg_req_o,  1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            set_in($urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 99) < 20, 12'($urandom), $urandom);
            step();
        end

        // Reset mid-stream with two loads buffered
        idle();
        step();
        step();
        set_in(1, 5'd9, 32'h9, 1, 5'd10, 32'hA0, 0, '0, '0);
        step();
        set_in(1, 5'd9, 32'h9, 1, 5'd11, 32'hB0, 0, '0, '0);
        step();
        chk("pre_rst_count", ld_count_o, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_reg_req",  w_reg_req_o,  0);
        chk("mid_rst_reg_addr", w_reg_addr_o, 0);
        chk("mid_rst_ready",    ld_ready_o,   1);
        chk("mid_rst_count",    ld_count_o,   0);
        chk("mid_rst_pending",  ld_pending_o, 0);
        model_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_req", w_reg_req_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
